sb_store_fwd: RTL and testbench

SB_STORE_FWD -- requirements
Module: sb_store_fwd

---
 rtl/sb_store_fwd.sv | 114 +++++++++++
 tb/tb_sb_store_fwd.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sb_store_fwd.sv
// Store-and-forward flit buffer: a packet becomes releasable once its last flit arrives, unless one partial
// packet fills the buffer, which forces cut-through (FORCE). Define SB_STORE_FWD_STATS_EN for packet counters.
module sb_store_fwd #(
  parameter int DW    = 416,
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic [31:0]   in_dest,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic [31:0]   out_dest,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] pkt_out_cnt,
  output logic [CW-1:0] forced_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  typedef enum logic {STORE, FORCE} state_t;

  state_t        state;
  logic [DW-1:0] mem_data [DEPTH];
  logic [31:0]   mem_dest [DEPTH];
  logic          mem_last [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count, committed, open_len;
  logic [NW-1:0] committed_dec;
  logic          push, pop;

  assign in_ready      = (count < NW'(DEPTH));
  assign out_valid     = (committed != '0);
  assign push          = in_valid && in_ready;
  assign pop           = out_valid && out_ready;
  assign committed_dec = committed - NW'(pop);

  assign out_data = mem_data[rd_ptr];
  assign out_dest = mem_dest[rd_ptr];
  assign out_last = mem_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_dest[wr_ptr] <= in_dest;
      mem_last[wr_ptr] <= in_last;
    end
  end

  // A full buffer with nothing releasable can only hold one partial packet; unblock it via FORCE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= STORE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      committed <= '0;
      open_len  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + NW'(push) - NW'(pop);
      case (state)
        STORE: begin
          if (count == NW'(DEPTH) && committed == '0) begin
            state     <= FORCE;
            committed <= open_len;
            open_len  <= '0;
          end else if (push && in_last) begin
            committed <= committed_dec + open_len + 1'b1;
            open_len  <= '0;
          end else if (push) begin
            committed <= committed_dec;
            open_len  <= open_len + 1'b1;
          end else begin
            committed <= committed_dec;
          end
        end
        FORCE: begin
          committed <= committed_dec + NW'(push);
          if (push && in_last) state <= STORE;
        end
        default: state <= STORE;
      endcase
    end
  end

`ifdef SB_STORE_FWD_STATS_EN
  logic [CW-1:0] pkt_q, forced_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q    <= '0;
      forced_q <= '0;
    end else begin
      if (pop && out_last) pkt_q <= pkt_q + 1'b1;
      if (state == FORCE && push && in_last) forced_q <= forced_q + 1'b1;
    end
  end

  assign pkt_out_cnt = pkt_q;
  assign forced_cnt  = forced_q;
`else
  assign pkt_out_cnt = '0;
  assign forced_cnt  = '0;
`endif

endmodule

// File: tb/tb_sb_store_fwd.sv
// Directed bench for sb_store_fwd: complete packets, forced cut-through, full buffer, streaming, mid-packet reset.
// Expected counter values follow SB_STORE_FWD_STATS_EN.
module tb_sb_store_fwd;
  localparam int DW    = 416;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
`ifdef SB_STORE_FWD_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [31:0]   dest;
    logic          last;
  } flit_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic [31:0]   in_dest;
  logic          in_last, in_valid, in_ready;
  logic [DW-1:0] out_data;
  logic [31:0]   out_dest;
  logic          out_last, out_valid, out_ready;
  logic [CW-1:0] pkt_out_cnt, forced_cnt;

  int    total = 0;
  int    bad = 0;
  int    exp_pkts = 0;
  flit_t expq[$];

  always #5 clk = ~clk;

  sb_store_fwd #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_dest(in_dest), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_dest(out_dest), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .pkt_out_cnt(pkt_out_cnt), .forced_cnt(forced_cnt)
  );

  function automatic logic [DW-1:0] mk_data(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {13{w}};
  endfunction

  function automatic logic [31:0] mk_dest(input int i);
    return 32'h1000_0000 + 32'(i * 3);
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Releases are scored just before the edge they happen on, against the order flits were accepted.
  task automatic tick();
    flit_t e;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checkOutput("spurious_release", 1, 0);
      end else begin
        e = expq.pop_front();
        checkOutput("out_data", out_data, e.data);
        checkOutput("out_dest", 32'(out_dest), 32'(e.dest));
        checkOutput("out_last", 1'(out_last), 1'(e.last));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic [31:0] dst, input logic lst, output int waited);
    logic  ok;
    flit_t f;
    in_valid = 1'b1;
    in_data  = d;
    in_dest  = dst;
    in_last  = lst;
    waited   = 0;
    forever begin
      ok = in_ready;
      tick();
      if (ok) begin
        f.data = d;
        f.dest = dst;
        f.last = lst;
        expq.push_back(f);
        break;
      end
      waited++;
      if (waited >= 30) begin
        checkOutput("accept_timeout", waited, 0);
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (expq.size() > 0 && n < 60) begin
      tick();
      n++;
    end
    checkOutput("drain_left", expq.size(), 0);
  endtask

  initial begin
    int w;
    logic [DW-1:0] hold_data;
    logic [31:0]   hold_dest;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = '0; in_last = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_out_valid", 1'(out_valid), 0);
    checkOutput("rst_in_ready", 1'(in_ready), 1);
    checkOutput("rst_pkt_cnt", pkt_out_cnt, 0);
    checkOutput("rst_forced_cnt", forced_cnt, 0);

    // Three-flit packet is held until its last flit arrives.
    out_ready = 1'b1;
    applyStimulus(mk_data(1), mk_dest(1), 1'b0, w);
    checkOutput("p3_hold1", 1'(out_valid), 0);
    applyStimulus(mk_data(2), mk_dest(2), 1'b0, w);
    checkOutput("p3_hold2", 1'(out_valid), 0);
    applyStimulus(mk_data(3), mk_dest(3), 1'b1, w);
    checkOutput("p3_valid", 1'(out_valid), 1);
    drain();
    exp_pkts += 1;
    checkOutput("p3_pkt_cnt", pkt_out_cnt, CW'(STATS * exp_pkts));
    checkOutput("p3_idle_valid", 1'(out_valid), 0);

    // Eight complete packets with the sink stalled fill the buffer without forcing.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) applyStimulus(mk_data(10 + i), mk_dest(10 + i), 1'b1, w);
    checkOutput("full_in_ready", 1'(in_ready), 0);
    checkOutput("full_out_valid", 1'(out_valid), 1);
    in_valid  = 1'b0;
    hold_data = out_data;
    hold_dest = out_dest;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("stall_data", out_data, hold_data);
    checkOutput("stall_dest", 32'(out_dest), 32'(hold_dest));
    checkOutput("stall_in_ready", 1'(in_ready), 0);
    checkOutput("stall_no_force", forced_cnt, 0);
    out_ready = 1'b1;
    tick();
    checkOutput("drain_in_ready", 1'(in_ready), 1);
    drain();
    exp_pkts += DEPTH;
    checkOutput("full_pkt_cnt", pkt_out_cnt, CW'(STATS * exp_pkts));

    // Twelve-flit packet overflows the buffer and goes through FORCE.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(mk_data(40 + i), mk_dest(40 + i), 1'(i == 11), w);
      if (i == DEPTH - 1) begin
        checkOutput("big_in_ready", 1'(in_ready), 0);
        checkOutput("big_no_valid", 1'(out_valid), 0);
      end
      if (i == DEPTH) checkOutput("big_force_wait", w, 2);
    end
    drain();
    exp_pkts += 1;
    checkOutput("big_forced_cnt", forced_cnt, CW'(STATS));
    checkOutput("big_pkt_cnt", pkt_out_cnt, CW'(STATS * exp_pkts));

    // Back-to-back single-flit packets stream at one per cycle.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(mk_data(100 + i), mk_dest(100 + i), 1'b1, w);
      checkOutput("stream_wait", w, 0);
      if (i > 0) checkOutput("stream_occupancy", expq.size(), 1);
    end
    drain();
    exp_pkts += 20;
    checkOutput("stream_pkt_cnt", pkt_out_cnt, CW'(STATS * exp_pkts));

    // Reset after two flits of a four-flit packet discards them.
    applyStimulus(mk_data(200), mk_dest(200), 1'b0, w);
    applyStimulus(mk_data(201), mk_dest(201), 1'b0, w);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expq.delete();
    checkOutput("mid_rst_valid", 1'(out_valid), 0);
    checkOutput("mid_rst_ready", 1'(in_ready), 1);
    checkOutput("mid_rst_pkt_cnt", pkt_out_cnt, 0);
    checkOutput("mid_rst_forced", forced_cnt, 0);
    tick();
    checkOutput("mid_rst_valid2", 1'(out_valid), 0);
    applyStimulus(mk_data(300), mk_dest(300), 1'b1, w);
    checkOutput("post_rst_valid", 1'(out_valid), 1);
    drain();
    checkOutput("post_rst_pkt_cnt", pkt_out_cnt, CW'(STATS));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
